// File: rtl/instr_issue_queue.sv
// Instruction FIFO feeding the cpu instruction port: each entry is held for HOLD_CYCLES,
// and readers of the rd written by the previous instruction are delayed by HAZARD_GAP bubbles.
module instr_issue_queue #(
    parameter int ILEN        = 32,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int HAZARD_GAP  = 2
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic                       flush,
    input  logic [ILEN-1:0]            in_instr,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ILEN-1:0]            cpu_instruction,
    output logic                       cpu_instruction_RDY_BSY,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = (HAZARD_GAP > 0) ? $clog2(HAZARD_GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STALL} state_t;

    logic [ILEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    state_t          state_q, state_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            rdy_q, rdy_d;
    logic            stall_q, stall_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            rec_v_q, rec_v_d;
    logic [4:0]      rec_rd_q, rec_rd_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            full, empty, push, pop;
    logic [ILEN-1:0] head;
    logic            head_blocked, head_blocked_new, new_flag;

    function automatic logic op_writes_rd(input logic [6:0] op);
        return op inside {7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                          7'b0000011, 7'b1101111, 7'b1100111};
    endfunction

    function automatic logic op_reads_rs1(input logic [6:0] op);
        return op inside {7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1100111};
    endfunction

    function automatic logic op_reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic depends_on(input logic [6:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd);
        return (op_reads_rs1(op) && rs1 == rd) || (op_reads_rs2(op) && rs2 == rd);
    endfunction

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    assign cpu_instruction         = instr_q;
    assign cpu_instruction_RDY_BSY = rdy_q;
    assign stall                   = stall_q;
    assign count                   = count_q;

    // A loaded gap value g releases the reader after exactly g idle cycles, so the
    // block only persists while more than one cycle of the gap remains.
    assign head_blocked = !empty && rec_v_q && (gap_q > GW'(1))
                          && depends_on(head[6:0], head[19:15], head[24:20], rec_rd_q);

    // Back-to-back check against the instruction finishing its hold this cycle.
    assign new_flag         = op_writes_rd(instr_q[6:0]) && (instr_q[11:7] != 5'd0);
    assign head_blocked_new = !empty && new_flag && (HAZARD_GAP != 0)
                              && depends_on(head[6:0], head[19:15], head[24:20], instr_q[11:7]);

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        rdy_d    = rdy_q;
        stall_d  = 1'b0;
        hold_d   = hold_q;
        rec_v_d  = rec_v_q;
        rec_rd_d = rec_rd_q;
        gap_d    = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE, S_STALL: begin
                rdy_d   = 1'b0;
                instr_d = '0;
                state_d = S_IDLE;
                if (!empty) begin
                    if (head_blocked) begin
                        state_d = S_STALL;
                        stall_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        instr_d = head;
                        rdy_d   = 1'b1;
                        hold_d  = HW'(HOLD_CYCLES);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (hold_q == HW'(1)) begin
                    rec_v_d  = new_flag;
                    rec_rd_d = instr_q[11:7];
                    if (new_flag) begin
                        gap_d = GW'(HAZARD_GAP);
                    end
                    if (!empty && !head_blocked_new) begin
                        pop     = 1'b1;
                        instr_d = head;
                        hold_d  = HW'(HOLD_CYCLES);
                    end else begin
                        rdy_d   = 1'b0;
                        instr_d = '0;
                        if (!empty) begin
                            state_d = S_STALL;
                            stall_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            instr_q  <= '0;
            rdy_q    <= 1'b0;
            stall_q  <= 1'b0;
            hold_q   <= '0;
            rec_v_q  <= 1'b0;
            rec_rd_q <= '0;
            gap_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            state_q  <= state_d;
            instr_q  <= instr_d;
            rdy_q    <= rdy_d;
            stall_q  <= stall_d;
            hold_q   <= hold_d;
            rec_v_q  <= rec_v_d;
            rec_rd_q <= rec_rd_d;
            gap_q    <= gap_d;
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed and random stimulus for instr_issue_queue, checked every cycle against a
// queue-based model that tracks issue times and the edge at which the last writer finished.
module tb_instr_issue_queue;

    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            cpu_clk = 1'b0;
    logic            cpu_rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic [ILEN-1:0] in_instr = '0;
    logic            in_ready;
    logic [ILEN-1:0] cpu_instruction;
    logic            cpu_instruction_RDY_BSY;
    logic            stall;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_q [$];
    logic        m_cur_v = 1'b0;
    logic [31:0] m_cur = '0;
    int          m_hold = 0;
    logic        m_rec_v = 1'b0;
    logic [4:0]  m_rec_rd = '0;
    int          m_end = 0;
    int          m_cyc = 0;
    logic        m_stall = 1'b0;

    instr_issue_queue #(
        .ILEN(ILEN), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .HAZARD_GAP(GAP)
    ) dut (
        .cpu_clk                 (cpu_clk),
        .cpu_rst                 (cpu_rst),
        .flush                   (flush),
        .in_instr                (in_instr),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .cpu_instruction         (cpu_instruction),
        .cpu_instruction_RDY_BSY (cpu_instruction_RDY_BSY),
        .stall                   (stall),
        .count                   (count)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic m_writes(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (op == 7'b0010011 || op == 7'b0110011 || op == 7'b0110111 || op == 7'b0010111 ||
                op == 7'b0000011 || op == 7'b1101111 || op == 7'b1100111) && ins[11:7] != 5'd0;
    endfunction

    function automatic logic m_dep(input logic [31:0] ins, input logic [4:0] rd);
        logic [6:0] op;
        logic r1, r2;
        op = ins[6:0];
        r1 = (op == 7'b0010011 || op == 7'b0110011 || op == 7'b0000011 ||
              op == 7'b0100011 || op == 7'b1100011 || op == 7'b1100111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return (r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, m_cyc, obs, exp);
        end
    endtask

    // One clock edge of the model: a dependent reader may go out at edge e only when
    // e - (edge its writer finished) >= GAP; otherwise the head waits and stall is shown.
    task automatic model_edge(input logic v, input logic [31:0] ins, input logic fl, input logic rs);
        int  pre_size;
        logic fin;
        m_cyc++;
        if (rs || fl) begin
            m_q.delete();
            m_cur_v = 1'b0; m_cur = '0; m_hold = 0;
            m_rec_v = 1'b0; m_rec_rd = '0; m_stall = 1'b0;
            return;
        end
        pre_size = m_q.size();
        fin = m_cur_v && (m_hold == 1);
        if (m_cur_v && !fin) m_hold--;
        if (fin) begin
            m_rec_v  = m_writes(m_cur);
            m_rec_rd = m_cur[11:7];
            m_end    = m_cyc;
            m_cur_v  = 1'b0;
            m_cur    = '0;
        end
        m_stall = 1'b0;
        if (!m_cur_v && m_q.size() > 0) begin
            if (m_rec_v && m_dep(m_q[0], m_rec_rd) && (m_cyc - m_end < GAP)) begin
                m_stall = 1'b1;
            end else begin
                m_cur   = m_q.pop_front();
                m_cur_v = 1'b1;
                m_hold  = HOLD;
                $display("issue %h at cycle %0d", m_cur, m_cyc);
            end
        end
        if (v && pre_size < DEPTH) m_q.push_back(ins);
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic fl, input logic rs);
        in_valid = v;
        in_instr = ins;
        flush    = fl;
        cpu_rst  = rs;
        #1;
        if (!rs) check("in_ready", in_ready, (m_q.size() < DEPTH) && !fl);
        @(posedge cpu_clk);
        model_edge(v, ins, fl, rs);
        #1;
        check("rdy_bsy", cpu_instruction_RDY_BSY, m_cur_v);
        check("instr", cpu_instruction, m_cur_v ? m_cur : 32'h0);
        check("stall", stall, m_stall);
        check("count", count, m_q.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 7))
            0: ins[6:0] = 7'b0010011;
            1: ins[6:0] = 7'b0110011;
            2: ins[6:0] = 7'b0110111;
            3: ins[6:0] = 7'b0000011;
            4: ins[6:0] = 7'b0100011;
            5: ins[6:0] = 7'b1100011;
            6: ins[6:0] = 7'b1101111;
            default: ins[6:0] = 7'b1110011;
        endcase
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        // Reset held for two cycles with in_valid asserted
        cycle(1'b1, 32'h00500093, 1'b0, 1'b1);
        cycle(1'b1, 32'h00500093, 1'b0, 1'b1);
        idle(2);

        // Writer then two dependent readers
        cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00508113, 1'b0, 1'b0);
        cycle(1'b1, 32'h002001B3, 1'b0, 1'b0);
        idle(16);

        // rd=x0 writer and an unrelated writer
        cycle(1'b1, 32'h00000013, 1'b0, 1'b0);
        cycle(1'b1, 32'h00000093, 1'b0, 1'b0);
        idle(8);

        // Writer, then a dependent reader arriving after the gap has elapsed
        cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
        idle(5);
        cycle(1'b1, 32'h00508113, 1'b0, 1'b0);
        idle(6);

        // Overfill the queue with independent lui instructions
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 32'h00000037 | (32'(i) << 7) | (32'(i) << 12), 1'b0, 1'b0);
        end
        idle(30);

        // Flush on the third hold cycle with two entries queued, then a reader of x1
        cycle(1'b1, 32'h00500093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00508113, 1'b0, 1'b0);
        cycle(1'b1, 32'h002001B3, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00000013, 1'b1, 1'b0);
        cycle(1'b1, 32'h00508113, 1'b0, 1'b0);
        idle(6);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 6, rand_instr(),
                  $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
